// File: rtl/freeze_key_decoder.sv
// rtl/freeze_key_decoder.sv - PS/2 set-2 Ctrl+Break decoder producing a rate-limited freeze pulse
module freeze_key_decoder #(
  parameter logic [19:0] HOLDOFF = 20'd1000000,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kbd_valid,
  input  logic [7:0] kbd_data,
  input  logic       enable,
  output logic       freeze,
  output logic       ctrl_held,
  output logic       busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] E0     = 3'd1;
  localparam logic [2:0] F0     = 3'd2;
  localparam logic [2:0] E0F0   = 3'd3;
  localparam logic [2:0] E1SKIP = 3'd4;

  localparam logic [7:0] CODE_CTRL  = 8'h14;
  localparam logic [7:0] CODE_BREAK = 8'h7E;

  logic [2:0]  state, state_nxt, cur_state;
  logic [2:0]  skip_cnt, skip_nxt;
  logic        lctrl, lctrl_nxt, rctrl, rctrl_nxt;
  logic [19:0] hold_cnt;
  logic [15:0] gap_cnt;
  logic        timeout_fire;
  logic        trigger;

  // Keyboard status/ack bytes that must never be read as make codes.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) ||
           (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  assign busy         = (hold_cnt != 20'd0);
  assign timeout_fire = (state != IDLE) && (gap_cnt == TIMEOUT);
  // A byte landing on the timeout cycle is decoded as if the FSM were already idle.
  assign cur_state    = timeout_fire ? IDLE : state;

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    lctrl_nxt = lctrl;
    rctrl_nxt = rctrl;
    trigger   = 1'b0;
    if (timeout_fire) begin
      state_nxt = IDLE;
      skip_nxt  = 3'd0;
    end
    if (kbd_valid) begin
      case (cur_state)
        IDLE: begin
          if (kbd_data == 8'hE0) begin
            state_nxt = E0;
          end else if (kbd_data == 8'hF0) begin
            state_nxt = F0;
          end else if (kbd_data == 8'hE1) begin
            state_nxt = E1SKIP;
            skip_nxt  = 3'd7;
          end else if (!is_ignored(kbd_data) && kbd_data == CODE_CTRL) begin
            lctrl_nxt = 1'b1;
          end
        end
        E0: begin
          if (kbd_data == 8'hF0) begin
            state_nxt = E0F0;
          end else if (kbd_data == 8'hE1) begin
            state_nxt = E1SKIP;
            skip_nxt  = 3'd7;
          end else begin
            state_nxt = IDLE;
            if (kbd_data == CODE_CTRL) rctrl_nxt = 1'b1;
            if (kbd_data == CODE_BREAK && ctrl_held && enable && !busy) trigger = 1'b1;
          end
        end
        F0: begin
          state_nxt = IDLE;
          if (kbd_data == CODE_CTRL) lctrl_nxt = 1'b0;
        end
        E0F0: begin
          state_nxt = IDLE;
          if (kbd_data == CODE_CTRL) rctrl_nxt = 1'b0;
        end
        E1SKIP: begin
          skip_nxt = skip_cnt - 3'd1;
          if (skip_cnt <= 3'd1) begin
            state_nxt = IDLE;
            skip_nxt  = 3'd0;
          end
        end
        default: begin
          state_nxt = IDLE;
          skip_nxt  = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      skip_cnt  <= 3'd0;
      lctrl     <= 1'b0;
      rctrl     <= 1'b0;
      ctrl_held <= 1'b0;
      freeze    <= 1'b0;
      hold_cnt  <= 20'd0;
      gap_cnt   <= 16'd0;
    end else begin
      state     <= state_nxt;
      skip_cnt  <= skip_nxt;
      lctrl     <= lctrl_nxt;
      rctrl     <= rctrl_nxt;
      ctrl_held <= lctrl_nxt | rctrl_nxt;
      freeze    <= trigger;
      if (trigger) begin
        hold_cnt <= HOLDOFF;
      end else if (hold_cnt != 20'd0) begin
        hold_cnt <= hold_cnt - 20'd1;
      end
      if (kbd_valid || state == IDLE) begin
        gap_cnt <= 16'd0;
      end else if (gap_cnt != TIMEOUT) begin
        gap_cnt <= gap_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_freeze_key_decoder.sv
// tb/tb_freeze_key_decoder.sv - directed-vector bench for freeze_key_decoder
module tb_freeze_key_decoder;

  localparam logic [19:0] HOLDOFF = 20'd50;
  localparam logic [15:0] TIMEOUT = 16'd20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       kbd_valid = 1'b0;
  logic [7:0] kbd_data = 8'h00;
  logic       enable = 1'b1;
  logic       freeze, ctrl_held, busy;

  int vectors = 0;
  int miscompares = 0;
  int fcnt = 0;
  int exp_f = 0;
  int ctrl_seen = 0;

  freeze_key_decoder #(.HOLDOFF(HOLDOFF), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .kbd_valid(kbd_valid), .kbd_data(kbd_data),
    .enable(enable), .freeze(freeze), .ctrl_held(ctrl_held), .busy(busy)
  );

  always #5 clk = ~clk;

  // Counted per sampled cycle, so a two-cycle pulse shows up as two freezes.
  always @(negedge clk) begin
    if (freeze) fcnt++;
    if (ctrl_held) ctrl_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    kbd_valid = 1'b1;
    kbd_data  = b;
    @(posedge clk); #1;
    kbd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (busy && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_fall", busy, 1'b0);
  endtask

  initial begin
    int n;
    // reset state
    reset = 1'b0;
    idle(3);
    check("rst_freeze", freeze, 1'b0);
    check("rst_ctrl", ctrl_held, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b1;
    idle(2);

    // basic Ctrl+Break with one-cycle pulse and HOLDOFF-cycle busy window
    send(8'h14);
    check("lctrl_make", ctrl_held, 1'b1);
    send(8'hE0);
    check("no_early_freeze", freeze, 1'b0);
    send(8'h7E);
    check("freeze_pulse", freeze, 1'b1);
    n = 0;
    while (busy && n < 500) begin
      n++;
      @(posedge clk); #1;
    end
    check("busy_len", n, HOLDOFF);
    exp_f = 1;
    check("freeze_cnt_basic", fcnt, exp_f);
    send(8'hF0); send(8'h14);
    check("lctrl_break", ctrl_held, 1'b0);

    // Pause sequence must not touch Ctrl state
    ctrl_seen = 0;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'hE0); send(8'h7E);
    idle(2);
    check("pause_ctrl_seen", ctrl_seen, 0);
    check("freeze_cnt_pause", fcnt, exp_f);

    // auto-repeat within holdoff gives one freeze, second allowed after busy falls
    send(8'h14);
    send(8'hE0); send(8'h7E);
    send(8'hE0); send(8'h7E);
    exp_f++;
    idle(2);
    check("freeze_cnt_repeat", fcnt, exp_f);
    wait_not_busy();
    send(8'hE0); send(8'h7E);
    exp_f++;
    idle(2);
    check("freeze_cnt_after_hold", fcnt, exp_f);
    wait_not_busy();
    send(8'hF0); send(8'h14);

    // right Ctrl make/break, then Break with no Ctrl
    send(8'hE0); send(8'h14);
    check("rctrl_make", ctrl_held, 1'b1);
    send(8'hE0); send(8'hF0); send(8'h14);
    check("rctrl_break", ctrl_held, 1'b0);
    send(8'hE0); send(8'h7E);
    idle(2);
    check("freeze_cnt_noctrl", fcnt, exp_f);

    // status bytes ignored; extended break 7E and plain 7E never trigger
    send(8'h14);
    send(8'hAA); send(8'hFA); send(8'hFE); send(8'hEE); send(8'h00); send(8'hFF);
    check("ignored_keep_ctrl", ctrl_held, 1'b1);
    send(8'hE0); send(8'hF0); send(8'h7E);
    send(8'h7E);
    idle(2);
    check("freeze_cnt_break7e", fcnt, exp_f);

    // timeout: long gap after E0 makes 7E a ScrollLock; Ctrl flags survive
    send(8'hE0);
    idle(TIMEOUT + 1);
    send(8'h7E);
    idle(2);
    check("freeze_cnt_timeout", fcnt, exp_f);
    check("timeout_keep_ctrl", ctrl_held, 1'b1);

    // timeout boundary: one cycle before still extended, on the firing cycle decoded from IDLE
    send(8'hE0);
    idle(TIMEOUT - 2);
    send(8'h7E);
    exp_f++;
    idle(2);
    check("freeze_cnt_edge_before", fcnt, exp_f);
    wait_not_busy();
    send(8'hE0);
    idle(TIMEOUT - 1);
    send(8'h7E);
    idle(2);
    check("freeze_cnt_edge_fire", fcnt, exp_f);
    send(8'hF0); send(8'h14);

    // enable low: decoded and consumed, no freeze, no holdoff
    enable = 1'b0;
    send(8'h14); send(8'hE0); send(8'h7E);
    idle(1);
    check("dis_busy", busy, 1'b0);
    enable = 1'b1;
    idle(2);
    check("freeze_cnt_disabled", fcnt, exp_f);

    // reset clears Ctrl; Break afterwards does nothing
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    check("rst_mid_ctrl", ctrl_held, 1'b0);
    send(8'hE0); send(8'h7E);
    idle(2);
    check("freeze_cnt_after_rst", fcnt, exp_f);

    // reset during holdoff clears busy
    send(8'h14); send(8'hE0); send(8'h7E);
    exp_f++;
    idle(3);
    check("busy_before_rst", busy, 1'b1);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    check("rst_hold_busy", busy, 1'b0);
    check("freeze_cnt_final", fcnt, exp_f);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/freeze_key_decoder.md
FREEZE_KEY_DECODER -- requirements
Module: freeze_key_decoder

Interface
REQ-001 Parameter HOLDOFF, default 20'd1000000; freeze re-trigger lockout length in clk cycles.
REQ-002 Parameter TIMEOUT, default 16'd50000; maximum clk cycles allowed between bytes of a multi-byte scancode sequence.
REQ-003 clk  input  1  system clock; all state changes on posedge clk.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 kbd_valid  input  1  one-cycle strobe; kbd_data holds a complete PS/2 set-2 byte.
REQ-006 kbd_data  input  8  received keyboard byte.
REQ-007 enable  input  1  freeze generation allowed; low while bootloader runs.
REQ-008 freeze  output  1  one-cycle freeze request to the cartridge block (edge-detected there).
REQ-009 ctrl_held  output  1  left or right Ctrl currently down.
REQ-010 busy  output  1  holdoff counter running.

Function
REQ-011 Prefix FSM SHALL have states IDLE, E0, F0, E0F0, E1SKIP; it advances only on cycles with kbd_valid=1.
REQ-012 IDLE: byte E0 -> E0; F0 -> F0; E1 -> E1SKIP with skip count 7; any other byte is a make code, processed, and the FSM stays in IDLE.
REQ-013 E0: F0 -> E0F0; E1 -> E1SKIP with skip count 7; any other byte is an extended make code, processed, -> IDLE.
REQ-014 F0: byte is a break code, processed, -> IDLE. E0F0: byte is an extended break code, processed, -> IDLE.
REQ-015 E1SKIP: each byte decrements the skip count; the FSM returns to IDLE after the 7th byte; bytes in E1SKIP (Pause sequence, contains 14/F0 14) SHALL NOT alter Ctrl state.
REQ-016 Ctrl tracking: make 14 sets lctrl; break 14 clears lctrl; extended make 14 sets rctrl; extended break 14 clears rctrl; ctrl_held = lctrl | rctrl, registered.
REQ-017 Break key = extended make 7E. If ctrl_held=1, enable=1 and busy=0 when that byte is processed, freeze SHALL be 1 for exactly the next clk cycle.
REQ-018 The same cycle freeze asserts, the 20-bit holdoff counter loads HOLDOFF; busy=1 while counter is nonzero; it decrements once per cycle and stops at 0.
REQ-019 While busy=1 or enable=0, a Break make SHALL be decoded and consumed, no freeze is produced, and the request is not queued.
REQ-020 Auto-repeat Break makes (no intervening break code) SHALL produce at most one freeze per holdoff window.
REQ-021 Extended break 7E and non-extended 7E (ScrollLock) SHALL never trigger freeze.
REQ-022 Timeout: a 16-bit gap counter clears on every kbd_valid; if FSM is not IDLE and the counter reaches TIMEOUT, FSM -> IDLE and skip count -> 0; Ctrl flags are unchanged.
REQ-023 kbd_valid arriving in the same cycle the timeout fires: the byte is processed from IDLE.
REQ-024 Bytes AA, FA, FE, EE, 00 and FF received in IDLE are ignored and do not change Ctrl state.
REQ-025 Latency: ctrl_held updates 1 cycle after the kbd_valid cycle; freeze asserts 1 cycle after the kbd_valid cycle carrying 7E.

Reset
REQ-026 While reset=0 at posedge clk: FSM=IDLE, skip count=0, lctrl=rctrl=0, holdoff counter=0, gap counter=0; freeze=0, ctrl_held=0, busy=0.
REQ-027 Reset asserted mid-sequence or during holdoff SHALL discard the sequence; no freeze is issued after reset releases until a full new Ctrl+Break is received.

Verification
REQ-028 enable=1; bytes 14, E0, 7E -> freeze=1 for one cycle, 1 cycle after 7E; busy=1 for HOLDOFF cycles.
REQ-029 E1 14 77 E1 F0 14 F0 77, then E0 7E -> ctrl_held stays 0 throughout; freeze never asserts.
REQ-030 14, E0 7E, E0 7E (2nd within HOLDOFF) -> exactly one freeze; after busy falls, E0 7E -> second freeze.
REQ-031 E0 14, E0 F0 14, E0 7E -> ctrl_held 1 then 0; no freeze. 14, E0, gap of TIMEOUT+1 cycles, 7E -> FSM back to IDLE, 7E is ScrollLock, no freeze.
REQ-032 enable=0 with 14 E0 7E -> no freeze, busy=0; reset=0 pulse after 14 -> ctrl_held=0, and a following E0 7E produces no freeze.
